// File: rtl/tt_um_bmsce_project_1.sv
// 2-bit magnitude comparator tile: combinational gt/eq/lt flags plus a registered
// copy of the result, a change pulse, and saturating entry counters for gt and lt.
module tt_um_bmsce_project_1 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [1:0] op_a;
   logic [1:0] op_b;
   logic       clr;
   logic [2:0] cmp;
   logic [2:0] r;
   logic       chg;
   logic [3:0] gt_cnt;
   logic [3:0] lt_cnt;
   logic       unused_inputs;

   assign op_a = ui_in[1:0];
   assign op_b = ui_in[3:2];
   assign clr  = ui_in[4];

   // {lt, eq, gt}: exactly one bit is always set
   assign cmp = {op_a < op_b, op_a == op_b, op_a > op_b};

   assign unused_inputs = &{1'b0, ui_in[7:5], uio_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r      <= 3'b000;
         chg    <= 1'b0;
         gt_cnt <= 4'd0;
         lt_cnt <= 4'd0;
      end else if (ena) begin
         r   <= cmp;
         chg <= (cmp != r);
         // entry = flag set now but not in the previously registered result
         if (clr)
            gt_cnt <= 4'd0;
         else if (cmp[0] && !r[0] && gt_cnt != 4'd15)
            gt_cnt <= gt_cnt + 4'd1;
         if (clr)
            lt_cnt <= 4'd0;
         else if (cmp[2] && !r[2] && lt_cnt != 4'd15)
            lt_cnt <= lt_cnt + 4'd1;
      end
   end

   assign uo_out  = {1'b0, chg, r, cmp};
   assign uio_out = {lt_cnt, gt_cnt};
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_bmsce_project_1.sv
// Directed bench for the comparator tile: combinational sweep, reset, counting,
// saturation, clear priority, enable hold and ignored-input checks.
module tb_tt_um_bmsce_project_1;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   tt_um_bmsce_project_1 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ops(input int a, input int b, input logic c);
      logic [7:0] v;
      v = 8'h00;
      v[1:0] = 2'(a);
      v[3:2] = 2'(b);
      v[4]   = c;
      return v;
   endfunction

   function automatic logic [2:0] exp_cmp(input int a, input int b);
      if (a > b) return 3'b001;
      if (a == b) return 3'b010;
      return 3'b100;
   endfunction

   logic [7:0] held_uo;
   logic [7:0] held_uio;

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // exhaustive combinational sweep, under reset
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            ui_in = ops(a, b, 1'b0);
            #10;
            chk($sformatf("cmp a=%0d b=%0d", a, b), uo_out[2:0], exp_cmp(a, b));
         end
      end

      // reset state with A=3, B=0
      ui_in = ops(3, 0, 1'b0);
      #3;
      chk("rst reg", uo_out[7:3], 5'b00000);
      chk("rst cnt", uio_out, 8'h00);
      chk("rst cmp", uo_out[2:0], 3'b001);
      chk("rst oe", uio_oe, 8'hFF);

      // first enabled edge after reset
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      step();
      chk("first r", uo_out[5:3], 3'b001);
      chk("first chg", uo_out[6], 1'b1);
      chk("first cnt", uio_out, 8'h01);
      step();
      chk("second chg", uo_out[6], 1'b0);
      chk("second cnt", uio_out, 8'h01);

      // alternate lt/gt for 40 edges; each edge is an entry into the new state
      for (int i = 0; i < 40; i++) begin
         int gt_e, lt_e;
         if (i % 2 == 0) ui_in = ops(0, 3, 1'b0);
         else            ui_in = ops(2, 1, 1'b0);
         step();
         lt_e = (i / 2 + 1 > 15) ? 15 : i / 2 + 1;
         gt_e = ((i + 1) / 2 + 1 > 15) ? 15 : (i + 1) / 2 + 1;
         chk($sformatf("alt chg %0d", i), uo_out[6], 1'b1);
         chk($sformatf("alt cnt %0d", i), uio_out, {4'(lt_e), 4'(gt_e)});
      end
      chk("saturated", uio_out, 8'hFF);

      // clear for one edge
      ui_in = ops(2, 1, 1'b1);
      step();
      chk("clear", uio_out, 8'h00);

      // clear and lt entry on the same edge: clear wins
      ui_in = ops(0, 3, 1'b1);
      step();
      chk("clr vs entry", uio_out, 8'h00);
      chk("clr vs entry r", uo_out[5:3], 3'b100);

      // constant lt: no new entry
      ui_in = ops(0, 3, 1'b0);
      step();
      chk("lt hold cnt", uio_out, 8'h00);
      chk("lt hold chg", uo_out[6], 1'b0);

      // lt -> gt -> lt
      ui_in = ops(3, 2, 1'b0);
      step();
      chk("to gt", uio_out, 8'h01);
      ui_in = ops(1, 2, 1'b0);
      step();
      chk("gt to lt", uio_out, 8'h11);
      chk("gt to lt r", uo_out[5:3], 3'b100);

      // equal state: no counting
      ui_in = ops(2, 2, 1'b0);
      step();
      chk("eq r", uo_out[6:3], 4'b1010);
      chk("eq cnt", uio_out, 8'h11);

      // ena=0: registers hold while comb output tracks
      held_uo  = uo_out;
      held_uio = uio_out;
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         int a, b;
         a = (i + 3) % 4;
         b = i % 4;
         ui_in = ops(a, b, i == 2);
         step();
         chk($sformatf("hold reg %0d", i), uo_out[6:3], held_uo[6:3]);
         chk($sformatf("hold cnt %0d", i), uio_out, held_uio);
         chk($sformatf("hold cmp %0d", i), uo_out[2:0], exp_cmp(a, b));
      end

      // ignored inputs: settle on A>B, then toggle ui_in[7:5] and uio_in
      ena   = 1'b1;
      ui_in = ops(3, 1, 1'b0);
      step();
      step();
      chk("settle uo", uo_out, 8'h09);
      chk("settle cnt", uio_out, 8'h12);
      for (int i = 0; i < 8; i++) begin
         ui_in[7:5] = 3'($urandom_range(0, 7));
         uio_in     = 8'($urandom_range(0, 255));
         step();
         chk($sformatf("ign uo %0d", i), uo_out, 8'h09);
         chk($sformatf("ign cnt %0d", i), uio_out, 8'h12);
      end
      ui_in[7:5] = 3'b000;
      uio_in     = 8'h00;

      // async reset mid-operation, then restart from reset values
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst reg", uo_out[7:3], 5'b00000);
      chk("mid rst cnt", uio_out, 8'h00);
      chk("mid rst cmp", uo_out[2:0], 3'b001);
      ui_in = ops(1, 1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("restart uo", uo_out, 8'h52);
      chk("restart cnt", uio_out, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
